// File: rtl/bootrom_shadow_loader.sv
// Boot ROM shadow loader.
// Copies the whole synchronous boot ROM into main RAM starting at RAM_BASE
// while holding the 6502 in reset, then releases the CPU a fixed number of
// cycles after the last RAM write is accepted. A restart pulse in DONE
// re-runs the copy.
module bootrom_shadow_loader #(
    parameter int                    ROM_ADDR_W  = 13,
    parameter int                    RAM_ADDR_W  = 16,
    parameter logic [RAM_ADDR_W-1:0] RAM_BASE    = 16'hE000,
    parameter int                    HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_we,
    input  logic                  ram_ready,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ROM_ADDR_W-1:0] IDX_LAST  = '1;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        COPY  = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [ROM_ADDR_W-1:0]   idx;
    logic [CNT_W-1:0]        hold_cnt;
    logic                    accept;

    // ram_we is high only in COPY, so this is the RAM handshake for the current byte
    assign accept    = ram_we & ram_ready;

    // rom_data always belongs to the registered idx, so it goes straight to RAM
    assign ram_wdata = rom_data;
    assign ram_addr  = RAM_BASE + RAM_ADDR_W'(idx);

    // Look one byte ahead on accept so the ROM latches the next byte on the same edge idx advances
    always_comb begin
        rom_addr = idx;
        if (state == COPY && accept && idx != IDX_LAST) begin
            rom_addr = idx + ROM_ADDR_W'(1);
        end
    end

    // Copy sequencer; control outputs are registered alongside the state so they never glitch on inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PRIME;
            idx         <= '0;
            hold_cnt    <= '0;
            ram_we      <= 1'b0;
            cpu_reset_n <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
        end else begin
            case (state)
                PRIME: begin
                    state  <= COPY;
                    ram_we <= 1'b1;
                end
                COPY: begin
                    if (accept) begin
                        if (idx == IDX_LAST) begin
                            // last byte: idx stays put, no wrap back to 0
                            state    <= HOLD;
                            ram_we   <= 1'b0;
                            hold_cnt <= '0;
                        end else begin
                            idx <= idx + ROM_ADDR_W'(1);
                        end
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= DONE;
                        cpu_reset_n <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                DONE: begin
                    if (restart) begin
                        state       <= PRIME;
                        idx         <= '0;
                        cpu_reset_n <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                default: begin
                    state <= PRIME;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bootrom_shadow_loader.sv
// Testbench for bootrom_shadow_loader.
// Three loaders share one clock: 16-byte ROM at E000, 16-byte ROM at FFF8
// (address wrap) and the full 8K ROM with random RAM back-pressure.
module tb_bootrom_shadow_loader;

    localparam int HOLD = 4;
    localparam int NI   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]       rstn, restart, ready;
    logic [3:0]       ra0, ra1;
    logic [12:0]      ra2;
    logic [2:0][15:0] rama;
    logic [2:0][7:0]  wd, rd;
    logic [2:0]       we, crn, bsy, dn;

    logic [7:0]  rom_img  [NI][8192];
    logic [15:0] log_addr [NI][8192];
    logic [7:0]  log_data [NI][8192];
    int wcnt[NI], first_acc[NI], last_acc[NI], first_done[NI], viol[NI];
    int n_chk = 0;
    int n_pass = 0;

    bootrom_shadow_loader #(.ROM_ADDR_W(4), .RAM_ADDR_W(16), .RAM_BASE(16'hE000), .HOLD_CYCLES(HOLD)) dut0 (
        .clk(clk), .rst_n(rstn[0]), .restart(restart[0]), .rom_addr(ra0), .rom_data(rd[0]),
        .ram_addr(rama[0]), .ram_wdata(wd[0]), .ram_we(we[0]), .ram_ready(ready[0]),
        .cpu_reset_n(crn[0]), .busy(bsy[0]), .done(dn[0]));

    bootrom_shadow_loader #(.ROM_ADDR_W(4), .RAM_ADDR_W(16), .RAM_BASE(16'hFFF8), .HOLD_CYCLES(HOLD)) dut1 (
        .clk(clk), .rst_n(rstn[1]), .restart(restart[1]), .rom_addr(ra1), .rom_data(rd[1]),
        .ram_addr(rama[1]), .ram_wdata(wd[1]), .ram_we(we[1]), .ram_ready(ready[1]),
        .cpu_reset_n(crn[1]), .busy(bsy[1]), .done(dn[1]));

    bootrom_shadow_loader dut2 (
        .clk(clk), .rst_n(rstn[2]), .restart(restart[2]), .rom_addr(ra2), .rom_data(rd[2]),
        .ram_addr(rama[2]), .ram_wdata(wd[2]), .ram_we(we[2]), .ram_ready(ready[2]),
        .cpu_reset_n(crn[2]), .busy(bsy[2]), .done(dn[2]));

    // Synchronous boot ROMs: data for the presented address appears one clock later
    always @(posedge clk) begin
        rd[0] <= rom_img[0][ra0];
        rd[1] <= rom_img[1][ra1];
        rd[2] <= rom_img[2][ra2];
    end

    function automatic int nbytes(input int i);
        return (i == 2) ? 8192 : 16;
    endfunction

    function automatic logic [15:0] base_of(input int i);
        return (i == 1) ? 16'hFFF8 : 16'hE000;
    endfunction

    function automatic int rom_addr_of(input int i);
        case (i)
            0:       return int'(ra0);
            1:       return int'(ra1);
            default: return int'(ra2);
        endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_log(input int i);
        wcnt[i]       = 0;
        first_acc[i]  = -1;
        last_acc[i]   = -1;
        first_done[i] = -1;
        viol[i]       = 0;
    endtask

    // RAM side observer: logs every accepted write and watches the CPU-release outputs
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rstn[i]) begin
                if (we[i] && ready[i]) begin
                    if (wcnt[i] < 8192) begin
                        log_addr[i][wcnt[i]] = rama[i];
                        log_data[i][wcnt[i]] = wd[i];
                    end
                    if (wcnt[i] == 0) first_acc[i] = cyc + 1;
                    last_acc[i] = cyc + 1;
                    wcnt[i]++;
                end
                if (crn[i] != dn[i] || bsy[i] == dn[i]) viol[i]++;
                if (crn[i] && wcnt[i] != nbytes(i)) viol[i]++;
                if (dn[i] && first_done[i] < 0) first_done[i] = cyc;
            end
        end
    end

    // Reference: byte k of the run must land at (base+k) mod 64K holding ROM[k]
    task automatic check_run(input int i, input string tag);
        int bad_a;
        int bad_d;
        logic [15:0] ea;
        bad_a = 0;
        bad_d = 0;
        chk({tag, " writes"}, wcnt[i], nbytes(i));
        for (int k = 0; k < nbytes(i) && k < wcnt[i]; k++) begin
            ea = base_of(i) + 16'(k);
            if (log_addr[i][k] != ea) bad_a++;
            if (log_data[i][k] != rom_img[i][k]) bad_d++;
        end
        chk({tag, " addr_errs"}, bad_a, 0);
        chk({tag, " data_errs"}, bad_d, 0);
        chk({tag, " hold_len"}, first_done[i], last_acc[i] + HOLD);
        chk({tag, " release_viol"}, viol[i], 0);
    endtask

    // Drives one copy run starting at the PRIME cycle after edge s.
    // mode 0: ready=1 with restart pulses in COPY and HOLD; 1: 3-cycle stall at idx 5;
    // 2: random ready; 3: async reset once idx reaches 7.
    task automatic run(input int i, input int mode, input int s, input int budget, input string tag);
        int k;
        clear_log(i);
        for (int n = 0; n < budget; n++) begin
            k = cyc - s;
            restart[i] = (mode == 0) && (k == 4 || k == 19);
            case (mode)
                1:       ready[i] = !(k >= 6 && k <= 8);
                2:       ready[i] = 1'($urandom_range(0, 1));
                default: ready[i] = 1'b1;
            endcase
            if (mode == 3 && k == 8) begin
                chk({tag, " pre_addr"}, rama[i], 16'hE007);
                #2;
                rstn[i] = 1'b0;
                #1;
                chk({tag, " rst_we"}, we[i], 0);
                chk({tag, " rst_cpu"}, crn[i], 0);
                chk({tag, " rst_romaddr"}, rom_addr_of(i), 0);
                chk({tag, " rst_ramaddr"}, rama[i], 16'hE000);
                chk({tag, " rst_busy"}, bsy[i], 1);
                chk({tag, " rst_done"}, dn[i], 0);
                return;
            end
            @(negedge clk);
            if (mode == 1 && k >= 6 && k <= 8) begin
                chk({tag, " stall_ramaddr"}, rama[i], 16'hE005);
                chk({tag, " stall_wdata"}, wd[i], 8'hA0);
                chk({tag, " stall_romaddr"}, rom_addr_of(i), 5);
                chk({tag, " stall_we"}, we[i], 1);
            end
            if (dn[i]) begin
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, " done_reached"}, 0, 1);
    endtask

    task automatic pulse_restart(input int i, output int s);
        @(posedge clk);
        #1;
        restart[i] = 1'b1;
        @(posedge clk);
        #1;
        restart[i] = 1'b0;
        s = cyc;
    endtask

    initial begin
        int s;
        rstn    = '0;
        restart = '0;
        ready   = '0;
        for (int k = 0; k < 8192; k++) begin
            rom_img[0][k] = 8'(k) ^ 8'hA5;
            rom_img[1][k] = 8'(k) ^ 8'hA5;
            rom_img[2][k] = 8'($urandom);
        end
        for (int i = 0; i < NI; i++) clear_log(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset cpu_reset_n", crn[0], 0);
        chk("reset busy", bsy[0], 1);
        chk("reset done", dn[0], 0);
        chk("reset ram_we", we[0], 0);
        chk("reset rom_addr", rom_addr_of(0), 0);
        chk("reset ram_addr", rama[0], 16'hE000);
        chk("reset ram_addr_wrapcfg", rama[1], 16'hFFF8);

        // full-speed copy; restart pulses while busy must be ignored
        @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        s = cyc;
        run(0, 0, s, 200, "run1");
        check_run(0, "run1");
        chk("run1 first_acc", first_acc[0], s + 2);
        chk("run1 last_acc", last_acc[0], s + 17);
        repeat (6) @(negedge clk);
        #1;
        chk("run1 no_rerun", wcnt[0], 16);
        chk("run1 still_done", dn[0], 1);

        // restart from DONE with a 3-cycle RAM stall at idx 5
        pulse_restart(0, s);
        chk("restart done_drop", dn[0], 0);
        chk("restart cpu_hold", crn[0], 0);
        run(0, 1, s, 200, "stall");
        check_run(0, "stall");
        chk("stall last_acc", last_acc[0], s + 20);

        // async reset in the middle of a copy, then a clean full rerun
        pulse_restart(0, s);
        run(0, 3, s, 200, "midrst");
        @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        s = cyc;
        run(0, 0, s, 200, "after_rst");
        check_run(0, "after_rst");
        chk("after_rst first_acc", first_acc[0], s + 2);

        // RAM address wrap past FFFF
        @(posedge clk);
        #1;
        rstn[1] = 1'b1;
        s = cyc;
        run(1, 0, s, 200, "wrap");
        check_run(1, "wrap");
        chk("wrap addr7", log_addr[1][7], 16'hFFFF);
        chk("wrap addr8", log_addr[1][8], 16'h0000);

        // full 8K image under random back-pressure
        @(posedge clk);
        #1;
        rstn[2] = 1'b1;
        s = cyc;
        run(2, 2, s, 40000, "rand8k");
        check_run(2, "rand8k");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
